// File: rtl/cache_arb_pkg.sv
// Shared types and sizing helpers for the cache/main-memory arbiter.
// Optional build macro: OTTER_ARB_IFETCH_PRIO_EN (fixed I-cache priority).
package cache_arb_pkg;

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} arb_state_t;
    typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

    // Bit positions of each requester inside the 2-bit req/gnt vectors
    localparam int IDX_I = 0;
    localparam int IDX_D = 1;

    // Default geometry of the OTTER_MCU memory port
    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_WORDS_PER_LINE = 4;

    // Width of the beat counter for a given line length
    function automatic int beat_w(input int words);
        return (words <= 1) ? 1 : $clog2(words);
    endfunction

    // Number of byte-offset bits inside one cache line
    function automatic int line_off_bits(input int words, input int data_w);
        return $clog2(words * (data_w / 8));
    endfunction

    // Number of byte-offset bits inside one memory word
    function automatic int byte_off_bits(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/arb2_rr.sv
// Two-way request picker with a registered last-grant pointer.
// With OTTER_ARB_IFETCH_PRIO_EN defined it becomes a fixed-priority picker
// (I-cache wins) and the pointer disappears.
module arb2_rr
    import cache_arb_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] gnt
);

`ifdef OTTER_ARB_IFETCH_PRIO_EN

    // Clock, reset and grant_en have no role without a pointer
    logic unused_prio;
    assign unused_prio = ^{CLK, RESET, grant_en};

    // Fixed priority: the instruction fetch path always wins a tie
    always_comb begin
        gnt = 2'b00;
        if (req[IDX_I]) begin
            gnt[IDX_I] = 1'b1;
        end else if (req[IDX_D]) begin
            gnt[IDX_D] = 1'b1;
        end
    end

`else

    owner_t last_q;
    owner_t last_d;

    // Round-robin pick: a lone request always wins, a tie goes to the side not served last
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt[IDX_I] = 1'b1;
            2'b10:   gnt[IDX_D] = 1'b1;
            2'b11: begin
                if (last_q == OWN_D) begin
                    gnt[IDX_I] = 1'b1;
                end else begin
                    gnt[IDX_D] = 1'b1;
                end
            end
            default: gnt = 2'b00;
        endcase
    end

    // Remember who was granted, only when the grant is actually taken
    always_comb begin
        last_d = last_q;
        if (grant_en && (req != 2'b00)) begin
            last_d = gnt[IDX_D] ? OWN_D : OWN_I;
        end
    end

    // Pointer register; reset marks the I-cache as last served so the D-cache is favoured
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            last_q <= OWN_I;
        end else begin
            last_q <= last_d;
        end
    end

`endif

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the single main-memory port between I-cache fills and D-cache
// fills/writebacks; each grant runs a WORDS_PER_LINE-beat burst.
// Optional build macro: OTTER_ARB_IFETCH_PRIO_EN (I-cache wins ties).
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
)(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_rvalid,
    output logic              ic_done,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_wready,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_rvalid,
    output logic              dc_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int BEAT_W = beat_w(WORDS_PER_LINE);
    localparam int OFF_W  = line_off_bits(WORDS_PER_LINE, DATA_W);
    localparam int BYTE_W = byte_off_bits(DATA_W);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_W-1:0] BASE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

    arb_state_t        state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [ADDR_W-1:0] base_q,  base_d;
    logic              we_q,    we_d;
    logic [BEAT_W-1:0] beat_q,  beat_d;

    logic [1:0] arb_req;
    logic [1:0] arb_gnt;
    logic       last_beat;

    assign arb_req   = {dc_req, ic_req};
    assign last_beat = (beat_q == LAST_BEAT);

    // Grants are only taken from IDLE, which also forces the turnaround cycle
    arb2_rr u_arb (
        .CLK      (CLK),
        .RESET    (RESET),
        .req      (arb_req),
        .grant_en (state_q == IDLE),
        .gnt      (arb_gnt)
    );

    // Next-state: latch owner/base/we at grant, count beats on each ack
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        base_d  = base_q;
        we_d    = we_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (arb_gnt != 2'b00) begin
                    state_d = BURST;
                    beat_d  = '0;
                    if (arb_gnt[IDX_D]) begin
                        owner_d = OWN_D;
                        base_d  = dc_addr & BASE_MASK;
                        we_d    = dc_we;
                    end else begin
                        owner_d = OWN_I;
                        base_d  = ic_addr & BASE_MASK;
                        we_d    = 1'b0;
                    end
                end
            end
            BURST: begin
                if (mem_ack) begin
                    if (last_beat) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: memory side driven from latched state, read data passed straight through on ack
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ic_rdata  = '0;
        ic_rvalid = 1'b0;
        ic_done   = 1'b0;
        dc_rdata  = '0;
        dc_rvalid = 1'b0;
        dc_wready = 1'b0;
        dc_done   = 1'b0;
        if (state_q == BURST) begin
            mem_req  = 1'b1;
            mem_we   = we_q;
            mem_addr = base_q + (ADDR_W'(beat_q) << BYTE_W);
            if ((owner_q == OWN_D) && we_q) begin
                mem_wdata = dc_wdata;
            end
            if (mem_ack) begin
                if (owner_q == OWN_I) begin
                    ic_rvalid = 1'b1;
                    ic_rdata  = mem_rdata;
                    ic_done   = last_beat;
                end else begin
                    if (we_q) begin
                        dc_wready = 1'b1;
                    end else begin
                        dc_rvalid = 1'b1;
                        dc_rdata  = mem_rdata;
                    end
                    dc_done = last_beat;
                end
            end
        end
    end

    // State registers; async reset abandons any burst in flight without a done pulse
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            owner_q <= OWN_I;
            base_q  <= '0;
            we_q    <= 1'b0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            base_q  <= base_d;
            we_q    <= we_d;
            beat_q  <= beat_d;
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus a
// randomized phase, all compared against a transaction-level model.
module tb_cache_mem_arbiter;

    localparam int WPL        = 4;
    localparam int LINE_BYTES = WPL * 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ic_req, dc_req, dc_we, mem_ack;
    logic [31:0] ic_addr, dc_addr, dc_wdata, mem_rdata;
    logic [31:0] ic_rdata, dc_rdata, mem_addr, mem_wdata;
    logic        ic_rvalid, ic_done, dc_wready, dc_rvalid, dc_done, mem_req, mem_we;

    cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WORDS_PER_LINE(WPL)) dut (
        .CLK(CLK), .RESET(RESET),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata),
        .ic_rvalid(ic_rvalid), .ic_done(ic_done),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_wready(dc_wready), .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid), .dc_done(dc_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic        m_busy;
    logic        m_owner;     // 0 = I-cache, 1 = D-cache
    logic        m_we;
    logic        m_last;      // side served most recently
    logic [31:0] m_base;
    logic [31:0] m_addrq[$];  // addresses still to be transferred in this burst
    logic        ev_ic_done, ev_dc_done;

    // observations collected per scenario
    logic [31:0] obs_addr[$];
    logic [31:0] obs_wdata[$];
    logic        obs_owner[$];
    int          ic_rv_cnt, dc_wr_cnt;

    task automatic model_reset();
        m_busy = 1'b0;
        m_last = 1'b0;   // I treated as last served, so D wins the first tie
        m_addrq.delete();
        ev_ic_done = 1'b0;
        ev_dc_done = 1'b0;
    endtask

    task automatic clear_obs();
        obs_addr.delete();
        obs_wdata.delete();
        obs_owner.delete();
        ic_rv_cnt = 0;
        dc_wr_cnt = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_memside"}, {mem_req, mem_we, mem_addr, mem_wdata}, 66'h0);
        check({tag, "_ic"}, {ic_rvalid, ic_done, ic_rdata}, 34'h0);
        check({tag, "_dc"}, {dc_rvalid, dc_wready, dc_done, dc_rdata}, 35'h0);
    endtask

    // Called with this cycle's inputs applied, away from the clock edge:
    // compare outputs, then advance the model across the coming rising edge.
    task automatic cycle();
        logic        was_busy, own;
        logic        e_req, e_we, e_ic_rv, e_ic_done, e_dc_rv, e_dc_wr, e_dc_done;
        logic [31:0] e_addr, e_wdata, e_ic_rdata, e_dc_rdata;
        was_busy = m_busy;
        e_req = 0; e_we = 0; e_ic_rv = 0; e_ic_done = 0; e_dc_rv = 0; e_dc_wr = 0; e_dc_done = 0;
        e_addr = 0; e_wdata = 0; e_ic_rdata = 0; e_dc_rdata = 0;
        if (m_busy) begin
            e_req   = 1'b1;
            e_addr  = m_addrq[0];
            e_we    = m_we;
            e_wdata = m_we ? dc_wdata : 32'h0;
            if (mem_ack) begin
                if (!m_owner) begin
                    e_ic_rv = 1'b1; e_ic_rdata = mem_rdata;
                end else if (m_we) begin
                    e_dc_wr = 1'b1;
                end else begin
                    e_dc_rv = 1'b1; e_dc_rdata = mem_rdata;
                end
                void'(m_addrq.pop_front());
                if (m_addrq.size() == 0) begin
                    m_busy = 1'b0;
                    if (m_owner) e_dc_done = 1'b1;
                    else         e_ic_done = 1'b1;
                    $display("burst: owner=%s base=0x%08h we=%0d t=%0t",
                             m_owner ? "D" : "I", m_base, m_we, $time);
                end
            end
        end
        check("mem_req", mem_req, e_req);
        if (e_req) begin
            check("mem_addr", mem_addr, e_addr);
            check("mem_we", mem_we, e_we);
            check("mem_wdata", mem_wdata, e_wdata);
        end
        check("ic_out", {ic_rvalid, ic_done, ic_rdata}, {e_ic_rv, e_ic_done, e_ic_rdata});
        check("dc_out", {dc_rvalid, dc_wready, dc_done, dc_rdata},
              {e_dc_rv, e_dc_wr, e_dc_done, e_dc_rdata});
        if (mem_req && mem_ack) begin
            obs_addr.push_back(mem_addr);
            obs_wdata.push_back(mem_wdata);
        end
        if (ic_rvalid) ic_rv_cnt++;
        if (dc_wready) dc_wr_cnt++;
        if (ic_done) obs_owner.push_back(1'b0);
        if (dc_done) obs_owner.push_back(1'b1);
        ev_ic_done = e_ic_done;
        ev_dc_done = e_dc_done;
        // grant for the coming edge, only from an idle cycle
        if (!was_busy && (ic_req || dc_req)) begin
            if (ic_req && dc_req) begin
`ifdef OTTER_ARB_IFETCH_PRIO_EN
                own = 1'b0;
`else
                own = ~m_last;
`endif
            end else begin
                own = dc_req;
            end
            m_last  = own;
            m_owner = own;
            m_we    = own ? dc_we : 1'b0;
            m_base  = (own ? dc_addr : ic_addr) & ~32'(LINE_BYTES - 1);
            for (int k = 0; k < WPL; k++) m_addrq.push_back(m_base + 32'(4 * k));
            m_busy  = 1'b1;
        end
    endtask

    // Entered at a falling edge with inputs set; leaves at the next falling edge
    task automatic step();
        #1;
        cycle();
        @(negedge CLK);
    endtask

    task automatic check_line(input string tag, input logic [31:0] base);
        logic [31:0] got;
        check({tag, "_beats"}, obs_addr.size(), WPL);
        for (int k = 0; k < WPL; k++) begin
            got = (k < obs_addr.size()) ? obs_addr[k] : 32'hFFFF_FFFF;
            check($sformatf("%s_addr%0d", tag, k), got, base + 32'(4 * k));
        end
    endtask

    // ---------------- random agents ----------------
    logic ic_pend, dc_pend;

    task automatic agents_random(input bit allow_new);
        if (ev_ic_done) begin
            ic_pend = allow_new && ($urandom_range(0, 1) == 1);
            if (ic_pend) ic_addr = $urandom;
        end else if (!ic_pend && allow_new && $urandom_range(0, 3) == 0) begin
            ic_pend = 1'b1; ic_addr = $urandom;
        end else if ($urandom_range(0, 7) == 0) begin
            ic_addr = $urandom;
        end
        if (ev_dc_done) begin
            dc_pend = allow_new && ($urandom_range(0, 1) == 1);
            if (dc_pend) dc_addr = $urandom;
        end else if (!dc_pend && allow_new && $urandom_range(0, 3) == 0) begin
            dc_pend = 1'b1; dc_addr = $urandom; dc_we = $urandom_range(0, 1) == 1;
        end
        ic_req    = ic_pend;
        dc_req    = dc_pend;
        mem_ack   = $urandom_range(0, 1) == 1;
        mem_rdata = $urandom;
        dc_wdata  = $urandom;
    endtask

    initial begin
        bit got;
        RESET = 1'b1;
        ic_req = 0; dc_req = 0; dc_we = 0; mem_ack = 0;
        ic_addr = 0; dc_addr = 0; dc_wdata = 0; mem_rdata = 0;
        ic_pend = 0; dc_pend = 0;
        model_reset();
        clear_obs();
        @(negedge CLK);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; dc_wdata = 32'h1234_5678;
        #1;
        check_all_zero("reset");
        @(negedge CLK);
        RESET = 1'b0;

        // I-cache line fill, ack every cycle
        clear_obs();
        ic_req = 1; ic_addr = 32'h0000_1234; mem_ack = 1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            mem_rdata = 32'h0C00_0000 + 32'(i);
            step();
            got = ev_ic_done;
        end
        ic_req = 0;
        check("t1_done_seen", got, 1'b1);
        check_line("t1", 32'h0000_1230);
        check("t1_rvalid_cnt", ic_rv_cnt, WPL);
        step();

        // D-cache writeback, ack every second cycle
        clear_obs();
        dc_req = 1; dc_we = 1; dc_addr = 32'h0000_8000;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            mem_ack  = i[0];
            dc_wdata = 32'hA0 + 32'(dc_wr_cnt);
            step();
            got = ev_dc_done;
        end
        dc_req = 0; dc_we = 0; mem_ack = 0;
        check("t2_done_seen", got, 1'b1);
        check("t2_wready_cnt", dc_wr_cnt, WPL);
        check_line("t2", 32'h0000_8000);
        for (int k = 0; k < WPL; k++)
            check($sformatf("t2_wdata%0d", k),
                  (k < obs_wdata.size()) ? obs_wdata[k] : 32'hFFFF_FFFF, 32'hA0 + 32'(k));
        step();

        // Both requesters high straight out of reset
        RESET = 1'b1;
        #1;
        model_reset();
        @(negedge CLK);
        RESET = 0;
        clear_obs();
        ic_req = 1; ic_addr = 32'h2000; dc_req = 1; dc_addr = 32'h3000; dc_we = 0; mem_ack = 1;
        for (int i = 0; i < 60 && obs_owner.size() < 3; i++) begin
            mem_rdata = $urandom;
            step();
        end
        ic_req = 0; dc_req = 0;
        check("t3_bursts", obs_owner.size(), 3);
        for (int k = 0; k < 3; k++) begin
`ifdef OTTER_ARB_IFETCH_PRIO_EN
            check($sformatf("t3_order%0d", k), (k < obs_owner.size()) ? obs_owner[k] : 1'bx, 1'b0);
`else
            check($sformatf("t3_order%0d", k), (k < obs_owner.size()) ? obs_owner[k] : 1'bx, k != 1);
`endif
        end
        step();

        // Reset during beat 2 of an I fill with a D request pending
        clear_obs();
        ic_req = 1; ic_addr = 32'h5000; mem_ack = 1;
        step();                       // idle: grant I
        dc_req = 1; dc_addr = 32'h6010; dc_we = 0;
        step();                       // beat 0
        step();                       // beat 1
        #1;
        cycle();                      // beat 2 checked
        check("t4_beat2_addr", mem_addr, 32'h5008);
        #1;
        RESET = 1'b1;
        #1;
        check_all_zero("t4_async");
        model_reset();
        ic_req = 0;
        @(negedge CLK);
        check_all_zero("t4_held");
        @(negedge CLK);
        RESET = 0;
        clear_obs();
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            mem_rdata = $urandom;
            step();
            got = ev_dc_done;
        end
        dc_req = 0;
        check("t4_dc_done", got, 1'b1);
        check_line("t4", 32'h6010);
        step();

        // I-cache address changes mid-burst, random wait states
        clear_obs();
        ic_req = 1; ic_addr = 32'h1234;
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            if (i == 2) ic_addr = 32'h4000;
            mem_ack = $urandom_range(0, 1) == 1;
            mem_rdata = $urandom;
            step();
            got = ev_ic_done;
        end
        ic_req = 0;
        check("t5_done_seen", got, 1'b1);
        check_line("t5", 32'h1230);
        step();

        // Randomized traffic, then drain
        for (int i = 0; i < 600; i++) begin
            agents_random(1'b1);
            step();
        end
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            agents_random(1'b0);
            step();
            got = !m_busy && !ic_pend && !dc_pend;
        end
        check("drain_idle", got, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single main-memory port of the OTTER_MCU between the instruction-cache miss/fill path and the data-cache fill/writeback path.
- Accepts whole-line requests from either cache and sequences each one as a burst of WORDS_PER_LINE single-word memory transactions.
- Uses 2-way round-robin arbitration.
- Sits between both caches and main memory inside OTTER_MCU.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, word width; beats step the address by DATA_W/8 bytes.
- WORDS_PER_LINE, 4, beats per line burst; must be a power of two, 2..16.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ic_req  in  1  I-cache line read request; held high until ic_done.
- ic_addr  in  ADDR_W  I-cache line address; offset bits ignored.
- ic_rdata  out  DATA_W  fill word.
- ic_rvalid  out  1  ic_rdata valid this cycle.
- ic_done  out  1  one-cycle pulse on the last beat.
- dc_req  in  1  D-cache line request; held high until dc_done.
- dc_we  in  1  1 = writeback, 0 = fill; stable while dc_req is high.
- dc_addr  in  ADDR_W  D-cache line address; offset bits ignored.
- dc_wdata  in  DATA_W  writeback word for the current beat.
- dc_wready  out  1  dc_wdata consumed this cycle.
- dc_rdata  out  DATA_W  fill word.
- dc_rvalid  out  1  dc_rdata valid this cycle.
- dc_done  out  1  one-cycle pulse on the last beat.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  word byte-address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data, valid when mem_ack=1.
- mem_ack  in  1  current beat complete; arbitrary wait states allowed.

Behaviour:
- Reset values:
  - All outputs 0.
  - State = IDLE, beat = 0.
  - RR pointer favours the D-cache.
  - Assertion clears immediately (async), abandoning any burst; no done pulse is issued.
- State IDLE:
  - mem_req = 0.
  - If either req is high, latch the owner (I or D), the line base (addr with low log2(WORDS_PER_LINE*DATA_W/8) bits zeroed) and dc_we if the owner is D. Go to BURST.
- Arbitration:
  - Single request: grant it.
  - Both requests: grant the requester not served last; update the pointer on grant.
- State BURST:
  - mem_req = 1.
  - mem_addr = base + beat*(DATA_W/8).
  - mem_we = latched we (I-cache is always 0).
  - mem_wdata = dc_wdata when the owner is D and writing, else 0.
- On mem_ack in BURST:
  - Owner read: owner rvalid = 1 and owner rdata = mem_rdata, same cycle, combinational passthrough.
  - Owner D write: dc_wready = 1.
  - beat increments.
  - Last beat (beat == WORDS_PER_LINE-1): owner done = 1 this cycle, beat returns to 0, state returns to IDLE.
- Latency:
  - Request to first mem_req: 1 cycle.
  - At least one IDLE cycle between bursts; this gives a one-cycle turnaround.
  - A req still high in the IDLE cycle after its done starts a new burst.
- Non-owner outputs:
  - rvalid, wready and done are always 0 for the non-owner.
  - rdata is 0 when rvalid = 0.
- Request changes mid-burst:
  - Owner req dropping mid-burst is ignored; the burst completes.
  - New or changed addr mid-burst is ignored (latched at grant).
- The beat counter is log2(WORDS_PER_LINE) bits wide and wraps only via completion.

Optional Feature:
- Macro OTTER_ARB_IFETCH_PRIO_EN.
- Defined: fixed priority, I-cache always wins simultaneous requests; the RR pointer is removed.
- Undefined: round-robin as above.

Decomposition:
- Package cache_arb_pkg holds:
  - typedef enum arb_state_t {IDLE, BURST}.
  - typedef enum owner_t {OWN_I, OWN_D}.
  - Localparam helpers: beat width, line offset bits.
- Sub-module arb2_rr: 2-way picker with a registered last-grant pointer.
  - Inputs: CLK, RESET, req[1:0], grant_en.
  - Output: one-hot gnt.
  - The macro compiles it to fixed priority.

Test Plan:
- ic_req=1, ic_addr=0x0000_1234, mem_ack=1 every cycle:
  - mem_addr sequence 0x1230, 0x1234, 0x1238, 0x123C.
  - ic_rvalid on 4 consecutive cycles; ic_done on the 4th.
- dc_req=1, dc_we=1, dc_addr=0x8000, dc_wdata=0xA0..A3, mem_ack every 2nd cycle:
  - mem_we=1, mem_wdata matches each beat.
  - dc_wready exactly 4 times; dc_done with the last ack.
- Both req high from reset:
  - D served first, then I after one IDLE cycle.
  - Repeated simultaneous requests alternate D, I, D.
  - With OTTER_ARB_IFETCH_PRIO_EN defined: I, I, I while ic_req stays high.
- Reset asserted during beat 2 of an I fill:
  - mem_req and all outputs go to 0 asynchronously.
  - After release, the pending dc_req is granted at beat 0.
- ic_addr changed to 0x4000 mid-burst:
  - mem_addr continues from the latched base 0x1230.
  - No extra beats; no glitch on dc_* outputs.
